// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman encoder front end: symbol/count widths,
// the count/emit state type and the node word packing used by every stage.
package huff_pkg;

  localparam int SYM_W  = 3;
  localparam int CNT_W  = 5;
  localparam int NODE_W = CNT_W + SYM_W;

  typedef enum logic {
    COUNT = 1'b0,
    EMIT  = 1'b1
  } state_t;

  // Count sits in the high bits so a plain compare of node words orders by weight.
  function automatic logic [NODE_W-1:0] pack_node(
    input logic [CNT_W-1:0] count,
    input logic [SYM_W-1:0] symbol
  );
    return {count, symbol};
  endfunction

endpackage

// File: rtl/freq_count.sv
// Symbol histogram builder: counts one symbol per cycle until the block's last
// symbol, then streams the histogram out as {count, symbol} leaf pairs.
module freq_count #(
  parameter int SYM_W = huff_pkg::SYM_W,
  parameter int CNT_W = huff_pkg::CNT_W
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [SYM_W-1:0]       sym_in,
  input  logic                   sym_valid,
  input  logic                   sym_last,
  output logic                   sym_ready,
  output logic [CNT_W+SYM_W-1:0] node1,
  output logic [CNT_W+SYM_W-1:0] node2,
  output logic                   node_valid,
  input  logic                   node_ready,
  output logic                   done
);

  import huff_pkg::*;

  localparam int NUM_SYM  = 1 << SYM_W;
  localparam int NUM_PAIR = NUM_SYM / 2;
  localparam int PAIR_W   = (SYM_W > 1) ? SYM_W - 1 : 1;
  localparam logic [PAIR_W-1:0] LAST_K  = PAIR_W'(NUM_PAIR - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W+SYM_W-1:0] leaf(
    input logic [CNT_W-1:0] count,
    input logic [SYM_W-1:0] symbol
  );
    return {count, symbol};
  endfunction

  state_t            state;
  logic [PAIR_W-1:0] k;
  logic [CNT_W-1:0]  cnt     [NUM_SYM];
  logic [CNT_W-1:0]  cnt_inc [NUM_SYM];
  logic [SYM_W-1:0]  even_nxt;
  logic [SYM_W-1:0]  odd_nxt;

  // Histogram as it would look after counting this cycle's symbol; lets the
  // first pair be loaded on the same edge as the final increment.
  always_comb begin
    for (int i = 0; i < NUM_SYM; i++) begin
      cnt_inc[i] = cnt[i];
      if (sym_valid && (sym_in == SYM_W'(i)) && (cnt[i] != CNT_MAX))
        cnt_inc[i] = cnt[i] + 1'b1;
    end
  end

  always_comb begin
    even_nxt = SYM_W'(2 * (int'(k) + 1));
    odd_nxt  = even_nxt + SYM_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= COUNT;
      k          <= '0;
      sym_ready  <= 1'b1;
      node1      <= '0;
      node2      <= '0;
      node_valid <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++)
        cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        COUNT: begin
          if (sym_valid) begin
            for (int i = 0; i < NUM_SYM; i++)
              cnt[i] <= cnt_inc[i];
            if (sym_last) begin
              state      <= EMIT;
              k          <= '0;
              sym_ready  <= 1'b0;
              node1      <= leaf(cnt_inc[0], SYM_W'(0));
              node2      <= leaf(cnt_inc[1], SYM_W'(1));
              node_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (node_valid && node_ready) begin
            if (k == LAST_K) begin
              // Clearing here means the next block starts from an empty histogram.
              state      <= COUNT;
              sym_ready  <= 1'b1;
              node_valid <= 1'b0;
              done       <= 1'b1;
              for (int i = 0; i < NUM_SYM; i++)
                cnt[i] <= '0;
            end else begin
              k     <= k + 1'b1;
              node1 <= leaf(cnt[even_nxt], even_nxt);
              node2 <= leaf(cnt[odd_nxt], odd_nxt);
            end
          end
        end
        default: state <= COUNT;
      endcase
    end
  end

endmodule

// File: doc/freq_count.md
Name: freq_count

Overview:
Upstream stage of the sort2 node comparator in the Huffman encoder.
- Accepts a stream of input symbols, one per cycle, and builds a per-symbol occurrence histogram.
- On end-of-stream, emits the histogram as leaf nodes, two per beat, on node1/node2, for sort2 to order.
- Node word = {count, symbol}, so comparing node words orders by weight first.

Parameters:
SYM_W, 3, symbol width; alphabet NUM_SYM = 2**SYM_W (localparam, always even).
CNT_W, 5, per-symbol counter width; node width NODE_W = CNT_W+SYM_W = 8 at defaults, matching sort2.

Ports:
CLK  in  1  clock, all logic on rising edge
nRST  in  1  synchronous active-low reset
sym_in  in  SYM_W  input symbol
sym_valid  in  1  sym_in valid this cycle
sym_last  in  1  qualifies the final symbol of a block (meaningful only with sym_valid)
sym_ready  out  1  high when symbols are accepted (COUNT state)
node1  out  NODE_W  even-indexed leaf {cnt[2k], 2k}
node2  out  NODE_W  odd-indexed leaf {cnt[2k+1], 2k+1}
node_valid  out  1  node1/node2 hold a valid pair
node_ready  in  1  downstream accepts pair
done  out  1  one-cycle pulse after the last pair is accepted

Behaviour:
Reset and clocking:
- Synchronous active-low: nRST sampled low at a CLK edge resets everything.
- Reset values: all counters 0, state COUNT, node1=0, node2=0, node_valid=0, done=0, sym_ready=1 (first cycle after reset).
- Reset mid-operation: aborts any count or emit in progress. Partial histogram is discarded; no partial pair is emitted.

States: COUNT, EMIT.
- COUNT:
  - sym_ready=1.
  - On sym_valid, cnt[sym_in] increments by 1, saturating at 2**CNT_W-1 (no wrap).
  - On sym_valid && sym_last: count that symbol, set pair index k=0, go to EMIT.
  - The output register loads {cnt[0],0}/{cnt[1],1} in the same edge, with node_valid=1. If sym_in is 0 or 1, the loaded value includes the final increment.
- EMIT:
  - sym_ready=0; sym_valid is ignored and nothing is counted.
  - Pair k is presented: node1={cnt[2k], 2k}, node2={cnt[2k+1], 2k+1}.
  - node1/node2/node_valid are registered and stable while node_valid && !node_ready.
  - Handshake on node_valid && node_ready:
    - If k < NUM_SYM/2-1: k increments and the next pair loads on the same edge, with no bubble.
    - If k = NUM_SYM/2-1: node_valid=0, done=1 for one cycle, all counters cleared, back to COUNT.
  - The cycle following done accepts new symbols (sym_ready=1).

Latency and throughput:
- Latency: last symbol accepted at edge N, so the first pair is valid in cycle N+1.
- Emit takes NUM_SYM/2 beats minimum (4 at defaults).

Other rules:
- A zero-count symbol is still emitted, e.g. {0,sym}; downstream filters.
- sym_last without sym_valid is ignored.
- Empty block: a single sym_valid&&sym_last is the minimum block; a block with no symbols does not exist.
- Counter increment is width-exact: no carry into the symbol field.

Decomposition:
Shared package huff_pkg holds:
- SYM_W, CNT_W, NODE_W constants
- state enum {COUNT, EMIT}
- node-pack function (count, symbol) -> NODE_W word, also used by sort2 and later tree-merge stages

No sub-module is needed. The counter array, FSM and output register live in one module.

Test Plan:
- Basic histogram: after reset, stream 3,3,5,0,3 (last on the final 3), node_ready=1 -> pairs (0x08,0x01), (0x02,0x1B), (0x04,0x0D), (0x06,0x07) on 4 consecutive cycles starting 1 cycle after last; done pulses after beat 4; sym_ready=0 during emit.
- Saturation: 40 consecutive symbol 2, last on the 40th -> pair 1 node1 = 0xFA (count 31), all other counts 0.
- Backpressure: node_ready=0 for 5 cycles on pair 0, then toggle 1/0 per cycle -> node1/node2 stable while stalled, each pair delivered exactly once in order, done only after the 4th accept.
- Ignored input: drive sym_valid=1 with sym_in=7 throughout EMIT -> no count change; the next block's pairs reflect only that block's symbols (counters cleared after done).
- Reset mid-operation: pull nRST low for 1 cycle while pair 1 is stalled -> next edge node_valid=0, node1/node2=0, sym_ready=1. A following block 1,1 (last) emits (0x00,0x11), (0x02,0x03), ... with no residue.
- Back-to-back blocks: send a new symbol the cycle after done -> accepted and counted.
